// File: rtl/axis_usb_reg_bridge.sv
// Host command decoder: 32-bit command words in, register bus writes/reads out,
// echo/status words and read data returned on an AXI-Stream output.
module axis_usb_reg_bridge #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [31:0]           bus_rdata
);

  localparam int unsigned CW = 12;
  localparam logic [3:0]  OP_NOP = 4'h0;
  localparam logic [3:0]  OP_WR  = 4'h1;
  localparam logic [3:0]  OP_RD  = 4'h2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_ACK,
    S_RD_ISSUE,
    S_RD_WAIT
  } state_t;

  state_t                r_state;
  logic [3:0]            r_op;
  logic [CW-1:0]         r_cnt;
  logic [31:0]           r_ack;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic w_s_hs;
  logic w_out_free;

  // Input is only accepted while parsing a header or streaming write data.
  assign s_axis_tready = aresetn & ((r_state == S_IDLE) | (r_state == S_WR_DATA));
  assign w_s_hs        = s_axis_tvalid & s_axis_tready;
  assign w_out_free    = ~m_axis_tvalid | m_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_op          <= OP_NOP;
      r_cnt         <= '0;
      r_ack         <= '0;
      r_addr        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_we        <= 1'b0;
      bus_re        <= 1'b0;
    end else begin
      bus_we <= 1'b0;
      bus_re <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_s_hs) begin
            r_op   <= s_axis_tdata[31:28];
            r_cnt  <= s_axis_tdata[27:16];
            r_addr <= s_axis_tdata[ADDR_WIDTH-1:0];
            case (s_axis_tdata[31:28])
              OP_NOP: r_state <= S_IDLE;
              OP_WR: begin
                r_ack   <= s_axis_tdata;
                r_state <= (s_axis_tdata[27:16] == '0) ? S_ACK : S_WR_DATA;
              end
              OP_RD: begin
                r_ack   <= s_axis_tdata;
                r_state <= S_ACK;
              end
              default: begin
                r_ack   <= {4'hF, s_axis_tdata[27:0]};
                r_state <= S_ACK;
              end
            endcase
          end
        end

        S_WR_DATA: begin
          if (w_s_hs) begin
            bus_we    <= 1'b1;
            bus_addr  <= r_addr;
            bus_wdata <= s_axis_tdata;
            r_addr    <= r_addr + ADDR_WIDTH'(1);
            r_cnt     <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_ACK;
          end
        end

        // The final bus_we is already on the bus when this state is entered.
        S_ACK: begin
          if (w_out_free) begin
            m_axis_tdata  <= r_ack;
            m_axis_tvalid <= 1'b1;
            r_state       <= ((r_op == OP_RD) && (r_cnt != '0)) ? S_RD_ISSUE : S_IDLE;
          end
        end

        S_RD_ISSUE: begin
          if (w_out_free) begin
            bus_re   <= 1'b1;
            bus_addr <= r_addr;
            r_state  <= S_RD_WAIT;
          end
        end

        // Output was free at issue time, so it is guaranteed empty here.
        S_RD_WAIT: begin
          m_axis_tdata  <= bus_rdata;
          m_axis_tvalid <= 1'b1;
          r_addr        <= r_addr + ADDR_WIDTH'(1);
          r_cnt         <= r_cnt - CW'(1);
          r_state       <= (r_cnt == CW'(1)) ? S_IDLE : S_RD_ISSUE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_usb_reg_bridge.sv
// Bench for axis_usb_reg_bridge: directed command scenarios plus randomized
// command streams checked against a transaction-level scoreboard.
module tb_axis_usb_reg_bridge;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;

  axis_usb_reg_bridge #(.ADDR_WIDTH(16)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_we        (bus_we),
    .bus_re        (bus_re),
    .bus_rdata     (bus_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Register file stand-in: read data derived from the address held on the bus.
  assign bus_rdata = 32'h0000_0100 | {16'h0000, bus_addr};

  int total = 0;
  int bad   = 0;
  int re_cnt = 0;
  int gapmax = 0;
  int tr_mode = 0;

  logic [31:0] q_out[$];
  logic [15:0] q_wa[$];
  logic [31:0] q_wd[$];
  logic [15:0] q_ra[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: actual=%08h required=no event at %0t", name, act, $time);
  endtask

  function automatic logic [31:0] rd_val(input logic [15:0] a);
    return 32'h0000_0100 | {16'h0000, a};
  endfunction

  // Output-ready pattern generator.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (tr_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Per-cycle compare against the scoreboard queues.
  logic        prev_v, prev_r;
  logic [31:0] prev_d;
  initial begin
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_v = 1'b0;
      end else begin
        if (bus_we || bus_re) check32("we_re_exclusive", 32'(bus_we & bus_re), 32'd0);
        if (bus_we) begin
          if (q_wa.size() == 0) fail_note("unexpected_we", {16'h0000, bus_addr});
          else begin
            check32("we_addr", {16'h0000, bus_addr}, {16'h0000, q_wa.pop_front()});
            check32("we_data", bus_wdata, q_wd.pop_front());
          end
        end
        if (bus_re) begin
          re_cnt++;
          if (q_ra.size() == 0) fail_note("unexpected_re", {16'h0000, bus_addr});
          else check32("re_addr", {16'h0000, bus_addr}, {16'h0000, q_ra.pop_front()});
        end
        if (prev_v && !prev_r) begin
          check32("hold_valid", 32'(m_axis_tvalid), 32'd1);
          check32("hold_data", m_axis_tdata, prev_d);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (q_out.size() == 0) fail_note("unexpected_out", m_axis_tdata);
          else check32("out_word", m_axis_tdata, q_out.pop_front());
        end
        prev_v = m_axis_tvalid;
        prev_r = m_axis_tready;
        prev_d = m_axis_tdata;
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    bit hs;
    hs = 1'b0;
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 500 && !hs; k++) begin
      @(negedge aclk);
      hs = s_axis_tready;
      @(posedge aclk);
    end
    if (!hs) fail_note("send_timeout", w);
    #1;
    s_axis_tvalid = 1'b0;
    if (gapmax > 0) begin
      for (int g = $urandom_range(0, gapmax); g > 0; g--) begin
        @(posedge aclk);
        #1;
      end
    end
  endtask

  // Model one command from its header, push expectations, then drive it.
  task automatic run_cmd(input logic [31:0] hdr);
    logic [3:0]  op;
    int          cnt;
    logic [15:0] a;
    logic [31:0] dd[$];
    op  = hdr[31:28];
    cnt = int'(hdr[27:16]);
    a   = hdr[15:0];
    dd.delete();
    if (op == 4'h1) begin
      for (int i = 0; i < cnt; i++) begin
        dd.push_back($urandom);
        q_wa.push_back(a + 16'(i));
        q_wd.push_back(dd[i]);
      end
      q_out.push_back(hdr);
    end else if (op == 4'h2) begin
      q_out.push_back(hdr);
      for (int i = 0; i < cnt; i++) begin
        q_ra.push_back(a + 16'(i));
        q_out.push_back(rd_val(a + 16'(i)));
      end
    end else if (op != 4'h0) begin
      q_out.push_back({4'hF, hdr[27:0]});
    end
    send_word(hdr);
    for (int i = 0; i < dd.size(); i++) send_word(dd[i]);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 5000 && !done; k++) begin
      @(posedge aclk);
      #2;
      done = (q_out.size() == 0) && (q_wa.size() == 0) && (q_ra.size() == 0) && !m_axis_tvalid;
    end
    check32({name, "_out_left"}, 32'(q_out.size()), 32'd0);
    check32({name, "_we_left"},  32'(q_wa.size()),  32'd0);
    check32({name, "_re_left"},  32'(q_ra.size()),  32'd0);
  endtask

  task automatic check_zero(input string name);
    check32({name, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    check32({name, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check32({name, "_m_tdata"},  m_axis_tdata,       32'd0);
    check32({name, "_bus_we"},   32'(bus_we),        32'd0);
    check32({name, "_bus_re"},   32'(bus_re),        32'd0);
    check32({name, "_bus_addr"}, {16'h0000, bus_addr}, 32'd0);
    check32({name, "_bus_wdata"}, bus_wdata,         32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    logic [3:0]  op;
    logic [15:0] a;
    int          sel;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    #3;
    check_zero("reset");
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check32("idle_tready", 32'(s_axis_tready), 32'd1);

    // Burst write of three words, ack after the writes.
    tr_mode = 0;
    q_wa.push_back(16'h0010); q_wd.push_back(32'h0000_000A);
    q_wa.push_back(16'h0011); q_wd.push_back(32'h0000_000B);
    q_wa.push_back(16'h0012); q_wd.push_back(32'h0000_000C);
    q_out.push_back(32'h1003_0010);
    send_word(32'h1003_0010);
    send_word(32'h0000_000A);
    send_word(32'h0000_000B);
    send_word(32'h0000_000C);
    drain("t1");

    // Read across the top of the address space.
    q_out.push_back(32'h2002_FFFF);
    q_out.push_back(32'h0000_FFFF);
    q_out.push_back(32'h0000_0100);
    q_ra.push_back(16'hFFFF);
    q_ra.push_back(16'h0000);
    send_word(32'h2002_FFFF);
    drain("t2");

    // Unknown op, then the following word is a fresh header.
    q_out.push_back(32'hF000_1234);
    q_wa.push_back(16'h0040); q_wd.push_back(32'h0000_0055);
    q_out.push_back(32'h1001_0040);
    send_word(32'h7000_1234);
    send_word(32'h1001_0040);
    send_word(32'h0000_0055);
    drain("t3");

    // Read with the output stalled for 20 cycles.
    tr_mode = 2;
    run_cmd(32'h2004_0100);
    snap = re_cnt;
    repeat (20) @(posedge aclk);
    #2;
    check32("stall_valid", 32'(m_axis_tvalid), 32'd1);
    check32("stall_data", m_axis_tdata, 32'h2004_0100);
    check32("stall_no_re", 32'(re_cnt), 32'(snap));
    tr_mode = 0;
    drain("t4");

    // Zero-length write and NOP.
    q_out.push_back(32'h1000_0005);
    send_word(32'h1000_0005);
    send_word(32'h0000_0000);
    drain("t5");

    // Reset in the middle of a write burst.
    q_wa.push_back(16'h0020); q_wd.push_back(32'hDEAD_0001);
    send_word(32'h1003_0020);
    send_word(32'hDEAD_0001);
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check_zero("midreset");
    check32("midreset_we_left", 32'(q_wa.size()), 32'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    q_out.push_back(32'h2001_0000);
    q_out.push_back(32'h0000_0100);
    q_ra.push_back(16'h0000);
    send_word(32'h2001_0000);
    drain("t6");

    // Randomized command mix with random stalls on both sides.
    tr_mode = 1;
    gapmax  = 2;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      op = 4'h0;
      else if (sel <= 4) op = 4'h1;
      else if (sel <= 8) op = 4'h2;
      else               op = 4'($urandom_range(3, 15));
      a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
      run_cmd({op, 12'($urandom_range(0, 5)), a});
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
